// File: rtl/wb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// wb_mem_arbiter
//
// Shares one Wishbone memory slave (boot ROM or RAM wrapper) between two bus
// masters. Grants are round-robin on ties and held for the whole bus cycle
// (while the granted master keeps cyc high). Ack and err are routed back only
// to the granted master. A watchdog ends a stalled slave access with a
// one-cycle error pulse once it has waited TIMEOUT cycles without a response.
//
// Parameters
//   AW       address width
//   DW       data width
//   TIMEOUT  slave stall limit in cycles (1..255)
//
// Ports
//   wb_clk_i, wb_rst_n_i          clock, asynchronous active-low reset
//   mN_cyc_i/stb_i/we_i           master N bus cycle, strobe, write enable
//   mN_adr_i/sel_i/dat_i          master N address, byte selects, write data
//   mN_dat_o/ack_o/err_o          master N read data, ack, error
//   s_cyc_o/stb_o/we_o            slave cycle, strobe, write enable
//   s_adr_o/sel_o/dat_o           slave address, byte selects, write data
//   s_dat_i/ack_i/err_i           slave read data, ack, error
// -----------------------------------------------------------------------------
module wb_mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_n_i,

    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [3:0]    m0_sel_i,
    input  logic [DW-1:0] m0_dat_i,
    output logic [DW-1:0] m0_dat_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,

    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [3:0]    m1_sel_i,
    input  logic [DW-1:0] m1_dat_i,
    output logic [DW-1:0] m1_dat_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,

    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [AW-1:0] s_adr_o,
    output logic [3:0]    s_sel_o,
    output logic [DW-1:0] s_dat_o,
    input  logic [DW-1:0] s_dat_i,
    input  logic          s_ack_i,
    input  logic          s_err_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    // Watchdog value seen in the last stalled cycle before the limit is hit.
    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic       last;
    logic       last_nxt;
    logic [7:0] wdog;
    logic [7:0] wdog_nxt;
    logic       counting;
    logic       timeout;

    // State, last-granted index and watchdog. Reset leaves master 1 as the
    // last grantee so master 0 wins the first tie.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state <= IDLE;
            last  <= 1'b1;
            wdog  <= 8'd0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            wdog  <= wdog_nxt;
        end
    end

    // Grant selection. A grant is held while the owner keeps cyc high; on
    // release the arbiter always passes through IDLE, where the other
    // master's pending request is picked up. Ties go to the master that was
    // not granted last.
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_nxt = last ? GNT0 : GNT1;
                end else if (m0_cyc_i) begin
                    state_nxt = GNT0;
                end else if (m1_cyc_i) begin
                    state_nxt = GNT1;
                end
            end
            GNT0: begin
                if (!m0_cyc_i) begin
                    state_nxt = IDLE;
                end
            end
            GNT1: begin
                if (!m1_cyc_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (state == IDLE && state_nxt == GNT0) begin
            last_nxt = 1'b0;
        end else if (state == IDLE && state_nxt == GNT1) begin
            last_nxt = 1'b1;
        end
    end

    // Slave-side mux, purely from the current grant so that an async reset
    // silences the slave immediately.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_sel_o = '0;
        s_dat_o = '0;
        case (state)
            GNT0: begin
                s_cyc_o = m0_cyc_i;
                s_stb_o = m0_stb_i;
                s_we_o  = m0_we_i;
                s_adr_o = m0_adr_i;
                s_sel_o = m0_sel_i;
                s_dat_o = m0_dat_i;
            end
            GNT1: begin
                s_cyc_o = m1_cyc_i;
                s_stb_o = m1_stb_i;
                s_we_o  = m1_we_i;
                s_adr_o = m1_adr_i;
                s_sel_o = m1_sel_i;
                s_dat_o = m1_dat_i;
            end
            default: ;
        endcase
    end

    // Watchdog: counts consecutive cycles of an outstanding strobe with no
    // slave response. The timeout fires in the cycle the stall reaches
    // TIMEOUT cycles, and the counter restarts on the following cycle so the
    // error is a single pulse. An ack in that same cycle suppresses the
    // timeout because the counting condition requires no response.
    assign counting = s_cyc_o & s_stb_o & ~s_ack_i & ~s_err_i;
    assign timeout  = counting & (wdog == WDOG_LAST);

    always_comb begin
        wdog_nxt = 8'd0;
        if (counting && !timeout) begin
            wdog_nxt = wdog + 8'd1;
        end
    end

    // Responses reach only the granted master; read data fans out to both.
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_ack_o = (state == GNT0) & s_ack_i;
    assign m1_ack_o = (state == GNT1) & s_ack_i;
    assign m0_err_o = (state == GNT0) & (s_err_i | timeout);
    assign m1_err_o = (state == GNT1) & (s_err_i | timeout);

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_mem_arbiter
//
// Drives two Wishbone masters into wb_mem_arbiter (TIMEOUT = 8) with a small
// ROM slave model whose ack delay can be programmed (0 = never ack). Expected
// read data is queued per master when a read is issued and compared when that
// master sees an ack. Grant order and idle gaps are recorded from the slave
// side and compared against the expected round-robin sequence.
// -----------------------------------------------------------------------------
module tb_wb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [31:0] TAG0 = 32'hAAAA_0000;
    localparam logic [31:0] TAG1 = 32'hBBBB_0001;

    logic          clock = 1'b0;
    logic          rst_n = 1'b0;

    logic          m0_cyc = 0, m0_stb = 0, m0_we = 0;
    logic [AW-1:0] m0_adr = '0;
    logic [3:0]    m0_sel = 4'hF;
    logic [DW-1:0] m0_dat = TAG0;
    logic [DW-1:0] m0_dat_o;
    logic          m0_ack_o, m0_err_o;

    logic          m1_cyc = 0, m1_stb = 0, m1_we = 0;
    logic [AW-1:0] m1_adr = '0;
    logic [3:0]    m1_sel = 4'hF;
    logic [DW-1:0] m1_dat = TAG1;
    logic [DW-1:0] m1_dat_o;
    logic          m1_ack_o, m1_err_o;

    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0] s_adr_o;
    logic [3:0]    s_sel_o;
    logic [DW-1:0] s_dat_o;
    logic [DW-1:0] sDat = '0;
    logic          sAck = 1'b0;
    logic          sErr = 1'b0;

    int            ackDelay = 1;
    int            waitCnt  = 0;
    bit            allowErr = 0;

    int            errors = 0;
    int            checks = 0;

    logic [31:0]   expQ0[$];
    logic [31:0]   expQ1[$];
    int            grantQ[$];
    int            gapQ[$];
    int            idleRun = 0;
    logic          prevCyc = 1'b0;

    wb_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
        .wb_clk_i   (clock),
        .wb_rst_n_i (rst_n),
        .m0_cyc_i   (m0_cyc),
        .m0_stb_i   (m0_stb),
        .m0_we_i    (m0_we),
        .m0_adr_i   (m0_adr),
        .m0_sel_i   (m0_sel),
        .m0_dat_i   (m0_dat),
        .m0_dat_o   (m0_dat_o),
        .m0_ack_o   (m0_ack_o),
        .m0_err_o   (m0_err_o),
        .m1_cyc_i   (m1_cyc),
        .m1_stb_i   (m1_stb),
        .m1_we_i    (m1_we),
        .m1_adr_i   (m1_adr),
        .m1_sel_i   (m1_sel),
        .m1_dat_i   (m1_dat),
        .m1_dat_o   (m1_dat_o),
        .m1_ack_o   (m1_ack_o),
        .m1_err_o   (m1_err_o),
        .s_cyc_o    (s_cyc_o),
        .s_stb_o    (s_stb_o),
        .s_we_o     (s_we_o),
        .s_adr_o    (s_adr_o),
        .s_sel_o    (s_sel_o),
        .s_dat_o    (s_dat_o),
        .s_dat_i    (sDat),
        .s_ack_i    (sAck),
        .s_err_i    (sErr)
    );

    // 100 MHz-style clock, rising edges at 5, 15, 25 ...
    always #5 clock = ~clock;

    // ROM contents as a pure function of the word index.
    function automatic logic [31:0] romWord(input logic [5:0] idx);
        return 32'hD00D_0000 + 32'(idx) * 32'd17;
    endfunction

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // ROM slave: registered ack after ackDelay cycles of strobe, never
    // acking back-to-back so each strobe gets exactly one ack.
    always @(posedge clock) begin
        if (s_cyc_o && s_stb_o && !sAck) begin
            if (ackDelay != 0 && waitCnt == ackDelay - 1) begin
                sAck    <= 1'b1;
                sDat    <= romWord(s_adr_o[7:2]);
                waitCnt <= 0;
            end else begin
                sAck    <= 1'b0;
                waitCnt <= waitCnt + 1;
            end
        end else begin
            sAck    <= 1'b0;
            waitCnt <= 0;
        end
    end

    // Response monitor: every ack pops that master's scoreboard entry; acks
    // must never reach both masters, and errors only appear when expected.
    // Grants are logged from s_cyc_o rising edges, tagged by the write data
    // each master drives, together with the idle run that preceded them.
    always @(negedge clock) begin
        if (!rst_n) begin
            prevCyc = 1'b0;
            idleRun = 0;
        end else begin
            checkOutput("ackOneHot", {31'b0, m0_ack_o & m1_ack_o}, 32'd0);
            if (m0_ack_o) begin
                if (expQ0.size() == 0) checkOutput("m0AckUnexpected", {31'b0, m0_ack_o}, 32'd0);
                else checkOutput("m0ReadData", m0_dat_o, expQ0.pop_front());
            end
            if (m1_ack_o) begin
                if (expQ1.size() == 0) checkOutput("m1AckUnexpected", {31'b0, m1_ack_o}, 32'd0);
                else checkOutput("m1ReadData", m1_dat_o, expQ1.pop_front());
            end
            if (!allowErr) checkOutput("errQuiet", {30'b0, m0_err_o, m1_err_o}, 32'd0);
            if (s_cyc_o && !prevCyc) begin
                grantQ.push_back((s_dat_o == TAG1) ? 1 : 0);
                gapQ.push_back(idleRun);
                idleRun = 0;
            end else if (!s_cyc_o) begin
                idleRun++;
            end
            prevCyc = s_cyc_o;
        end
    end

    // Issues one read for master m, queues the expected ROM word, waits
    // (bounded) for the ack and then drops stb -- and cyc unless keepCyc --
    // inside the ack cycle. Returns the number of falling edges to the ack.
    task automatic applyStimulus(input int m, input logic [31:0] adr, input bit keepCyc, output int lat);
        bit got;
        if (m == 0) begin
            expQ0.push_back(romWord(adr[7:2]));
            m0_adr = adr; m0_cyc = 1'b1; m0_stb = 1'b1;
        end else begin
            expQ1.push_back(romWord(adr[7:2]));
            m1_adr = adr; m1_cyc = 1'b1; m1_stb = 1'b1;
        end
        got = 0;
        lat = 0;
        while (!got && lat < 60) begin
            @(negedge clock);
            lat++;
            got = (m == 0) ? m0_ack_o : m1_ack_o;
        end
        if (!got) checkOutput("ackWaitExpired", 32'(m), 32'hFFFF_FFFF);
        #1;
        if (m == 0) begin
            m0_stb = 1'b0;
            if (!keepCyc) m0_cyc = 1'b0;
        end else begin
            m1_stb = 1'b0;
            if (!keepCyc) m1_cyc = 1'b0;
        end
        @(posedge clock);
        #1;
    endtask

    // Quiet reset with both masters idle, released just after a rising edge.
    task automatic applyReset();
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clock);
        #1 rst_n = 1'b1;
        grantQ.delete();
        gapQ.delete();
    endtask

    // Safety net so the bench always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL simTimeLimit reached, got=running expected=finished");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        int lat;
        int lat1;
        int errCnt;
        int errAt;
        int stbCycles;
        bit m1ErrSeen;
        time m0DoneTime;
        time m1AckTime;

        // Reset with both masters requesting: slave side and responses quiet.
        m0_cyc = 1; m1_cyc = 1; m0_adr = 32'h40; m1_adr = 32'h80;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutput("rstScyc", {31'b0, s_cyc_o}, 32'd0);
        checkOutput("rstAckErr", {28'b0, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 32'd0);
        @(posedge clock);
        #1 rst_n = 1'b1;
        @(negedge clock);
        checkOutput("rstNoGrantYet", {31'b0, s_cyc_o}, 32'd0);
        @(negedge clock);
        checkOutput("rstGrant0Cyc", {31'b0, s_cyc_o}, 32'd1);
        checkOutput("rstGrant0Adr", s_adr_o, 32'h40);
        checkOutput("rstGrant0Dat", s_dat_o, TAG0);
        applyReset();

        // Single read from master 1 at 0x10 (ROM word 4): ack two cycles
        // after the request is first seen.
        @(posedge clock); #1;
        applyStimulus(1, 32'h10, 0, lat);
        checkOutput("m1ReadLatency", 32'(lat), 32'd3);

        // Fairness: both masters request twice back to back from reset.
        applyReset();
        @(posedge clock); #1;
        fork
            begin
                applyStimulus(0, 32'h20, 0, lat);
                applyStimulus(0, 32'h24, 0, lat);
            end
            begin
                applyStimulus(1, 32'h14, 0, lat1);
                applyStimulus(1, 32'h18, 0, lat1);
            end
        join
        checkOutput("fairGrantCount", 32'(grantQ.size()), 32'd4);
        for (int i = 0; i < 4 && i < grantQ.size(); i++) begin
            checkOutput($sformatf("fairGrant%0d", i), 32'(grantQ[i]), 32'(i % 2));
            if (i > 0) checkOutput($sformatf("fairIdleGap%0d", i), 32'(gapQ[i]), 32'd1);
        end

        // Lock: master 0 keeps cyc over four strobes while master 1 waits.
        grantQ.delete();
        gapQ.delete();
        @(posedge clock); #1;
        fork
            begin
                for (int i = 0; i < 4; i++) applyStimulus(0, 32'h30 + 32'(4 * i), (i < 3), lat);
                m0DoneTime = $time;
            end
            begin
                @(posedge clock); #1;
                applyStimulus(1, 32'h3C, 0, lat1);
                m1AckTime = $time;
            end
        join
        checkOutput("lockM1AfterM0", {31'b0, m1AckTime > m0DoneTime}, 32'd1);
        checkOutput("lockGrantCount", 32'(grantQ.size()), 32'd2);
        if (grantQ.size() == 2) begin
            checkOutput("lockFirstGrant", 32'(grantQ[0]), 32'd0);
            checkOutput("lockSecondGrant", 32'(grantQ[1]), 32'd1);
        end
        checkOutput("scoreboardEmpty", 32'(expQ0.size() + expQ1.size()), 32'd0);

        // Watchdog: slave never acks; master 0 drops the cycle on the error.
        ackDelay = 0;
        allowErr = 1;
        errCnt = 0; errAt = 0; stbCycles = 0; m1ErrSeen = 0;
        @(posedge clock); #1;
        m0_adr = 32'h08; m0_cyc = 1; m0_stb = 1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (s_stb_o) stbCycles++;
            if (m1_err_o) m1ErrSeen = 1;
            if (m0_err_o) begin
                errCnt++;
                errAt = stbCycles;
                #1 m0_cyc = 0; m0_stb = 0;
            end
        end
        checkOutput("wdogPulseCount", 32'(errCnt), 32'd1);
        checkOutput("wdogPulseCycle", 32'(errAt), 32'd8);
        checkOutput("wdogOtherMaster", {31'b0, m1ErrSeen}, 32'd0);
        m0_cyc = 0; m0_stb = 0;
        @(posedge clock); #1;
        allowErr = 0;

        // Ack arriving in the very cycle the watchdog would fire: ack only.
        ackDelay = 7;
        applyStimulus(0, 32'h0C, 0, lat);
        checkOutput("wdogAckWinsLatency", 32'(lat), 32'd9);
        ackDelay = 1;

        // Async reset while master 1 is granted and its ack is on the bus.
        @(posedge clock); #1;
        m1_adr = 32'h04; m1_cyc = 1; m1_stb = 1;
        @(posedge clock);
        @(posedge clock); #1;
        checkOutput("arstPreAck", {31'b0, m1_ack_o}, 32'd1);
        checkOutput("arstPreCyc", {31'b0, s_cyc_o}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("arstScycDrop", {31'b0, s_cyc_o}, 32'd0);
        checkOutput("arstAckDrop", {31'b0, m1_ack_o}, 32'd0);
        m1_cyc = 0; m1_stb = 0;
        void'(expQ1.size());
        repeat (2) @(posedge clock);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_mem_arbiter.md
# wb_mem_arbiter

Two-master Wishbone arbiter that shares a single memory slave (boot ROM or RAM wrapper) between two bus masters, e.g. CPU instruction port and a debug/DMA port. It grants the slave with round-robin fairness, holds the grant for the master's whole bus cycle, and routes ack/err back to the granted master only. A watchdog ends any slave access that stalls beyond a programmable limit with an error response.

## Interface
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 255, slave stall limit in cycles (1..255, 8-bit counter)

- wb_clk_i  in  1  clock, all logic on rising edge
- wb_rst_n_i  in  1  asynchronous, active-low reset
- m0_cyc_i / m1_cyc_i  in  1  master cycle request
- m0_stb_i / m1_stb_i  in  1  master strobe
- m0_we_i / m1_we_i  in  1  master write enable
- m0_adr_i / m1_adr_i  in  AW  master address
- m0_sel_i / m1_sel_i  in  4  master byte selects
- m0_dat_i / m1_dat_i  in  DW  master write data
- m0_dat_o / m1_dat_o  out  DW  read data, both driven from s_dat_i
- m0_ack_o / m1_ack_o  out  1  ack to master
- m0_err_o / m1_err_o  out  1  error to master
- s_cyc_o, s_stb_o, s_we_o  out  1  slave controls
- s_adr_o  out  AW; s_sel_o  out  4; s_dat_o  out  DW  slave address/select/write data
- s_dat_i  in  DW; s_ack_i  in  1; s_err_i  in  1  slave response

## Operation
- State register: IDLE, GNT0, GNT1. Registers: state, last (index of last granted master), wdog (8-bit).
- IDLE: if only mN_cyc_i high -> GNTN. If both high -> grant the master != last. Neither -> stay IDLE.
- Entering GNTN sets last = N.
- GNTN: stay while mN_cyc_i high. mN_cyc_i low -> IDLE (always one IDLE cycle between grants; other master's request is seen there).
- Slave mux (combinational from state): GNTN drives s_cyc/stb/we/adr/sel/dat_o from master N with s_cyc_o = mN_cyc_i. IDLE drives all slave outputs 0.
- Responses: mN_ack_o = (state==GNTN) & s_ack_i; mN_err_o = (state==GNTN) & (s_err_i | timeout). Non-granted master sees 0.
- Watchdog: wdog increments each cycle s_cyc_o & s_stb_o & ~s_ack_i & ~s_err_i; clears to 0 otherwise. timeout = (wdog == TIMEOUT-1) & counting condition; wdog clears the cycle after timeout.
- Simultaneous s_ack_i and timeout: ack wins, no err.
- Master drops cyc in same cycle as its ack: legal; ack delivered, transition to IDLE.
- Reset (any time, async): state=IDLE, last=1 (master 0 wins first tie), wdog=0. In-flight access is abandoned; all slave outputs and mN_ack_o/mN_err_o go 0 immediately.

## Timing
- Grant latency: mN_cyc_i rising at edge t -> GNTN after edge t+1 -> slave sees request in cycle t+1.
- With single-cycle-ack slave (ack registered one cycle after cyc&stb): master ack in cycle t+2.
- Back-to-back from other master: release at edge r -> IDLE cycle r..r+1 -> other grant visible from r+1 edge.
- Timeout err asserted in the cycle where the stalled access reaches TIMEOUT cycles without response; one-cycle pulse per stall.
- No combinational path from mN_cyc_i to state; outputs are combinational from state plus master/slave inputs.

## Test plan
- Reset: hold wb_rst_n_i=0 with both cyc high -> s_cyc_o=0, all ack/err 0; release -> GNT0 one cycle later, s_adr_o = m0_adr_i.
- Single master read: m1 reads adr 0x10 from ROM slave (ack one cycle after stb) -> m1_ack_o in cycle t+2 with m1_dat_o = ROM word 4; m0_ack_o stays 0.
- Fairness: both masters hold cyc and issue one access, then release and re-request -> grant sequence 0,1,0,1 with one IDLE cycle between each.
- Lock: m0 holds cyc across 4 stb accesses while m1 requests -> all 4 acks to m0, m1 granted only after m0_cyc_i drops.
- Watchdog: TIMEOUT=8, slave never acks -> m0_err_o pulses exactly once, 8 cycles after s_stb_o asserts; ack on that same cycle instead -> ack, no err.
- Async reset mid-access: assert wb_rst_n_i low while GNT1 and stb pending -> s_cyc_o and m1_ack_o drop without waiting for clock edge.
